// File: rtl/song_sequencer.sv
// Table-driven song player: walks a {end, dur, note} song ROM at a runtime tempo and
// drives note/gate to the tone stage, with pause, restart and loop/one-shot handling.
module song_sequencer #(
  parameter int ADDR_W   = 9,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 4,
  parameter int DIV_W    = 24,
  parameter int TICK_DIV = 6250000,
  parameter int ARTIC    = 1
) (
  input  logic                      clk50,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      restart,
  input  logic                      loop_en,
  input  logic [DIV_W-1:0]          tempo_div,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_rd,
  input  logic [DUR_W+NOTE_W:0]     rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic                      gate,
  output logic                      tick,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   count;
  logic [DIV_W-1:0]   period_m1;
  logic [DUR_W-1:0]   remaining;
  logic [DUR_W-1:0]   dur_loaded;
  logic               end_flag;
  logic               run;
  logic               entry_done;

  // Tick period: 0 selects the default, anything below 4 is clamped so no tick
  // can land while an entry is being fetched.
  always_comb begin
    if (tempo_div == '0) begin
      period_m1 = DIV_W'(TICK_DIV - 1);
    end else if (tempo_div < DIV_W'(4)) begin
      period_m1 = DIV_W'(3);
    end else begin
      period_m1 = tempo_div - DIV_W'(1);
    end
  end

  assign run        = play && ((state == FETCH) || (state == WAIT) || (state == PLAY));
  assign tick       = run && (count >= period_m1);
  assign entry_done = tick && (state == PLAY) && (remaining == '0);

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rom_rd    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (restart) begin
      state_nxt = play ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:  if (play) state_nxt = FETCH;
        FETCH: state_nxt = WAIT;
        WAIT:  state_nxt = PLAY;
        PLAY: begin
          if (entry_done) begin
            state_nxt = (!end_flag || loop_en) ? FETCH : DONE;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
    case (state)
      FETCH: begin
        rom_rd = 1'b1;
        busy   = 1'b1;
      end
      WAIT:    busy = 1'b1;
      PLAY:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      rom_addr   <= '0;
      count      <= '0;
      note       <= '0;
      remaining  <= '0;
      dur_loaded <= '0;
      end_flag   <= 1'b0;
    end else if (restart) begin
      rom_addr   <= '0;
      count      <= '0;
      note       <= '0;
      remaining  <= '0;
      dur_loaded <= '0;
      end_flag   <= 1'b0;
    end else begin
      if (tick) begin
        count <= '0;
      end else if (run) begin
        count <= count + DIV_W'(1);
      end
      case (state)
        WAIT: begin
          note       <= rom_data[NOTE_W-1:0];
          remaining  <= rom_data[NOTE_W +: DUR_W];
          dur_loaded <= rom_data[NOTE_W +: DUR_W];
          end_flag   <= rom_data[NOTE_W+DUR_W];
        end
        PLAY: begin
          if (tick) begin
            if (remaining != '0) begin
              remaining <= remaining - DUR_W'(1);
            end else if (!end_flag) begin
              rom_addr <= rom_addr + ADDR_W'(1);
            end else if (loop_en) begin
              rom_addr <= '0;
            end else begin
              note <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Old note stays on the output across FETCH/WAIT; articulation gap only for multi-tick entries.
  assign gate = play && (state != DONE) && (note != '0) &&
                !((ARTIC != 0) && (remaining == '0) && (dur_loaded != '0));

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: one-shot, loop, pause, restart-on-tick,
// tempo default/clamp and reset-during-fetch scenarios.
module tb_song_sequencer;

  localparam int ADDR_W = 4;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 4;
  localparam int DIV_W  = 24;
  localparam int TDIV   = 20;

  logic                  clk50;
  logic                  reset;
  logic                  play;
  logic                  restart;
  logic                  loop_en;
  logic [DIV_W-1:0]      tempo_div;
  logic [ADDR_W-1:0]     rom_addr;
  logic                  rom_rd;
  logic [DUR_W+NOTE_W:0] rom_data;
  logic [NOTE_W-1:0]     note;
  logic                  gate;
  logic                  tick;
  logic                  busy;
  logic                  done;

  logic [DUR_W+NOTE_W:0] mem [16];
  int compared;
  int mismatched;
  int fetch6_cnt;
  int f6;
  int n;

  localparam logic [5:0] NC = 6'd10;
  localparam logic [5:0] NE = 6'd14;
  localparam logic [5:0] NG = 6'd17;

  song_sequencer #(
    .ADDR_W  (ADDR_W),
    .NOTE_W  (NOTE_W),
    .DUR_W   (DUR_W),
    .DIV_W   (DIV_W),
    .TICK_DIV(TDIV),
    .ARTIC   (1)
  ) dut (
    .clk50    (clk50),
    .reset    (reset),
    .play     (play),
    .restart  (restart),
    .loop_en  (loop_en),
    .tempo_div(tempo_div),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_data (rom_data),
    .note     (note),
    .gate     (gate),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  initial begin
    rom_data   = '0;
    fetch6_cnt = 0;
  end

  always @(posedge clk50) begin
    if (rom_rd) begin
      rom_data <= mem[rom_addr];
      if (rom_addr == 4'd6) fetch6_cnt <= fetch6_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic seg(input string tag, input logic [5:0] nt, input logic g, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk50);
      chk({tag, "_note"}, 32'(note), 32'(nt));
      chk({tag, "_gate"}, 32'(gate), 32'(g));
    end
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk50);
      cnt++;
    end while (tick !== 1'b1 && cnt < 200);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_rd"},   32'(rom_rd),   0);
    chk({tag, "_note"}, 32'(note),     0);
    chk({tag, "_gate"}, 32'(gate),     0);
    chk({tag, "_tick"}, 32'(tick),     0);
    chk({tag, "_busy"}, 32'(busy),     0);
    chk({tag, "_done"}, 32'(done),     0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk50);
    restart = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    play       = 1'b0;
    restart    = 1'b0;
    loop_en    = 1'b0;
    tempo_div  = 24'd4;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    mem[0] = {1'b0, 4'd1, NC};
    mem[1] = {1'b0, 4'd0, NE};
    mem[2] = {1'b1, 4'd2, NG};

    repeat (3) @(negedge clk50);
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk50);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rd", 32'(rom_rd), 0);

    // 1) one-shot song
    play = 1'b1;
    @(negedge clk50);
    chk("t1_fetch_rd", 32'(rom_rd), 1);
    chk("t1_fetch_busy", 32'(busy), 1);
    @(negedge clk50);
    chk("t1_wait_rd", 32'(rom_rd), 0);
    chk("t1_wait_note", 32'(note), 0);
    seg("t1_c_hi", NC, 1'b1, 2);
    chk("t1_first_tick", 32'(tick), 1);
    seg("t1_c_lo", NC, 1'b0, 6);
    seg("t1_e", NE, 1'b1, 4);
    seg("t1_g_hi", NG, 1'b1, 6);
    chk("t1_g_addr", 32'(rom_addr), 2);
    seg("t1_g_lo", NG, 1'b0, 4);
    chk("t1_last_tick", 32'(tick), 1);
    @(negedge clk50);
    chk("t1_done", 32'(done), 1);
    chk("t1_done_note", 32'(note), 0);
    chk("t1_done_gate", 32'(gate), 0);
    chk("t1_done_busy", 32'(busy), 0);
    repeat (10) @(negedge clk50);
    chk("t1_done_sticky", 32'(done), 1);
    chk("t1_done_hold_note", 32'(note), 0);

    // 2) looping song
    loop_en = 1'b1;
    pulse_restart();
    chk("t2_restart_done", 32'(done), 0);
    chk("t2_restart_rd", 32'(rom_rd), 1);
    @(negedge clk50);
    for (int r = 0; r < 3; r++) begin
      seg("t2_c_hi", NC, 1'b1, 2);
      seg("t2_c_lo", NC, 1'b0, 6);
      seg("t2_e", NE, 1'b1, 4);
      seg("t2_g_hi", NG, 1'b1, 6);
      seg("t2_g_lo", NG, 1'b0, 6);
      chk("t2_wrap_addr", 32'(rom_addr), 0);
      chk("t2_not_done", 32'(done), 0);
    end
    seg("t2_c_again", NC, 1'b1, 1);

    // 3) pause mid-note
    tempo_div = 24'd10;
    loop_en   = 1'b0;
    pulse_restart();
    @(negedge clk50);
    seg("t3_c_pre", NC, 1'b1, 3);
    play = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk50);
      chk("t3_pause_gate", 32'(gate), 0);
      chk("t3_pause_tick", 32'(tick), 0);
      chk("t3_pause_note", 32'(note), 32'(NC));
    end
    play = 1'b1;
    seg("t3_resume", NC, 1'b1, 4);
    @(negedge clk50);
    chk("t3_resume_tick", 32'(tick), 1);
    chk("t3_resume_tick_gate", 32'(gate), 1);
    seg("t3_last", NC, 1'b0, 9);
    @(negedge clk50);
    chk("t3_end_tick", 32'(tick), 1);
    @(negedge clk50);
    chk("t3_next_rd", 32'(rom_rd), 1);
    chk("t3_next_addr", 32'(rom_addr), 1);
    @(negedge clk50);
    @(negedge clk50);
    chk("t3_next_note", 32'(note), 32'(NE));

    // 4) restart coincident with tick at address 5
    for (int k = 0; k < 16; k++) mem[k] = {1'b0, 4'd0, 6'(k + 1)};
    tempo_div = 24'd4;
    f6 = fetch6_cnt;
    pulse_restart();
    repeat (23) @(negedge clk50);
    chk("t4_tick_at5", 32'(tick), 1);
    chk("t4_addr5", 32'(rom_addr), 5);
    chk("t4_note6", 32'(note), 6);
    pulse_restart();
    chk("t4_addr0", 32'(rom_addr), 0);
    chk("t4_rd", 32'(rom_rd), 1);
    chk("t4_note_clr", 32'(note), 0);
    @(negedge clk50);
    @(negedge clk50);
    chk("t4_first_note", 32'(note), 1);
    chk("t4_first_gate", 32'(gate), 1);
    chk("t4_no_fetch6", 32'(fetch6_cnt), 32'(f6));

    // 5) default tempo, mid-count decrease and clamp
    mem[0]    = {1'b0, 4'd15, 6'd1};
    tempo_div = '0;
    pulse_restart();
    wait_tick(n);
    wait_tick(n);
    chk("t5_default_p1", 32'(n), 32'(TDIV));
    wait_tick(n);
    chk("t5_default_p2", 32'(n), 32'(TDIV));
    repeat (10) @(negedge clk50);
    chk("t5_mid_no_tick", 32'(tick), 0);
    tempo_div = 24'd2;
    #1;
    chk("t5_decrease_tick", 32'(tick), 1);
    wait_tick(n);
    chk("t5_clamp_p1", 32'(n), 4);
    wait_tick(n);
    chk("t5_clamp_p2", 32'(n), 4);
    chk("t5_note_held", 32'(note), 1);

    // 6) reset during WAIT
    mem[0]    = {1'b0, 4'd0, 6'd1};
    tempo_div = 24'd4;
    pulse_restart();
    repeat (5) @(negedge clk50);
    chk("t6_wait_addr", 32'(rom_addr), 1);
    chk("t6_wait_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    chk("t6_fetch_rd", 32'(rom_rd), 1);
    chk("t6_fetch_addr", 32'(rom_addr), 0);
    @(negedge clk50);
    @(negedge clk50);
    chk("t6_note", 32'(note), 1);
    chk("t6_gate", 32'(gate), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
